// File: rtl/aes_pkg.sv
// Shared AES types, key-length lookups, Rcon table and GF(2^8) helpers for
// the iterative encryptor and its S-box.
package aes_pkg;

  typedef enum logic {ST_IDLE, ST_ROUND} fsm_e;

  // Element 0 is the most significant byte, matching FIPS-197 byte order.
  typedef logic [0:3][7:0]  word_t;
  typedef logic [0:15][7:0] state_t;

  localparam logic [7:0] RCON_TBL [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                           8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  function automatic int aes_nr(input int key_bits);
    return (key_bits == 256) ? 14 : (key_bits == 192) ? 12 : 10;
  endfunction

  function automatic int aes_nk(input int key_bits);
    return key_bits / 32;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    if (idx >= 4'd1 && idx <= 4'd10) return RCON_TBL[idx - 4'd1];
    return 8'h00;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p  = 8'h00;
    aa = a;
    bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = xtime(aa);
      bb = bb >> 1;
    end
    return p;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box: multiplicative inverse in GF(2^8) (as x^254) followed by
// the FIPS-197 affine transform.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  logic [7:0] inv, pw;

  always_comb begin
    inv = 8'h01;
    pw  = in_byte;
    // Product of x^2, x^4, ... x^128 is x^254; zero maps to zero.
    for (int i = 1; i < 8; i++) begin
      pw  = gf_mul(pw, pw);
      inv = gf_mul(inv, pw);
    end
    out_byte = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end

endmodule

// File: rtl/aes_iterative_encryptor.sv
// Iterative AES-128/192/256 encryptor, one round per clock, with the key
// schedule expanded four words per cycle. Optional macro: AES_ZEROIZE_EN.
module aes_iterative_encryptor
  import aes_pkg::*;
#(
  parameter int KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start_aes,
  input  logic [127:0]        text,
  input  logic [KEY_BITS-1:0] aes_key,
  output logic [127:0]        ciphertext,
  output logic                encryptor_done,
  output logic                busy
);

  localparam int NR = aes_nr(KEY_BITS);
  localparam int NK = aes_nk(KEY_BITS);

  if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
    $error("KEY_BITS must be 128, 192 or 256");
  end

  fsm_e         fsm_q, fsm_d;
  state_t       state_q, state_d;
  word_t        win_q [8];
  word_t        win_d [8];
  logic [3:0]   rnd_q, rnd_d;
  logic [127:0] ct_q, ct_d;
  logic         done_q, done_d;

  logic [255:0] key_pad;
  word_t        key_w [8];
  word_t        ext [12];
  word_t        sub_in, sub_out, tmp;
  logic [5:0]   j;
  state_t       sb, sr, mc, rk;
  logic         last_rnd;

  assign last_rnd = (rnd_q == 4'(NR));

  always_comb begin
    key_pad = 256'(aes_key) << (256 - KEY_BITS);
    for (int k = 0; k < 8; k++) key_w[k] = key_pad[255 - 32*k -: 32];
  end

  // Window holds the last eight schedule words; in round 1 the slots 0..3
  // still carry the raw key words 4..NK-1, which override the generator.
  always_comb begin : key_sub_sel
    sub_in = win_q[7];
    if (NK == 6 && (rnd_q % 4'd3) == 4'd1)
      sub_in = (rnd_q == 4'd1) ? win_q[1] : (win_q[2] ^ win_q[3] ^ win_q[7]);
  end

  for (genvar b = 0; b < 4; b++) begin : g_ksbox
    aes_sbox u_ksbox (.in_byte(sub_in[b]), .out_byte(sub_out[b]));
  end

  // Round r produces w[4r..4r+3]; at most one of them needs SubWord.
  always_comb begin : key_expand
    tmp = '0;
    j   = '0;
    for (int k = 0; k < 8; k++) ext[k] = win_q[k];
    for (int k = 8; k < 12; k++) ext[k] = '0;
    for (int m = 0; m < 4; m++) begin
      j = {rnd_q, 2'b00} + 6'(m);
      if ((j % NK) == 0)
        tmp = {sub_out[1], sub_out[2], sub_out[3], sub_out[0]} ^ {rcon(4'(j / NK)), 24'h0};
      else if (NK == 8 && (j % 8) == 4)
        tmp = sub_out;
      else
        tmp = ext[7+m];
      ext[8+m] = ext[8+m-NK] ^ tmp;
      if (rnd_q == 4'd1 && 4 + m < NK) ext[8+m] = win_q[m];
    end
  end

  assign rk = {ext[8], ext[9], ext[10], ext[11]};

  for (genvar i = 0; i < 16; i++) begin : g_sbox
    aes_sbox u_sbox (.in_byte(state_q[i]), .out_byte(sb[i]));
  end

  always_comb begin : shift_mix
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        sr[c*4 + r] = sb[((c + r) % 4)*4 + r];
    for (int c = 0; c < 4; c++) begin
      mc[c*4+0] = xtime(sr[c*4]) ^ xtime(sr[c*4+1]) ^ sr[c*4+1] ^ sr[c*4+2] ^ sr[c*4+3];
      mc[c*4+1] = sr[c*4] ^ xtime(sr[c*4+1]) ^ xtime(sr[c*4+2]) ^ sr[c*4+2] ^ sr[c*4+3];
      mc[c*4+2] = sr[c*4] ^ sr[c*4+1] ^ xtime(sr[c*4+2]) ^ xtime(sr[c*4+3]) ^ sr[c*4+3];
      mc[c*4+3] = xtime(sr[c*4]) ^ sr[c*4] ^ sr[c*4+1] ^ sr[c*4+2] ^ xtime(sr[c*4+3]);
    end
  end

  always_comb begin : datapath_next
    state_d = state_q;
    win_d   = win_q;
    rnd_d   = rnd_q;
    ct_d    = ct_q;
    done_d  = 1'b0;
    case (fsm_q)
      ST_IDLE: if (start_aes) begin
        state_d = text ^ key_pad[255:128];
        for (int k = 0; k < 4; k++) begin
          win_d[4+k] = key_w[k];
          win_d[k]   = (4 + k < NK) ? key_w[4+k] : '0;
        end
        rnd_d = 4'd1;
      end
      ST_ROUND: begin
        for (int k = 0; k < 8; k++) win_d[k] = ext[4+k];
        if (last_rnd) begin
          state_d = sr ^ rk;
          ct_d    = sr ^ rk;
          done_d  = 1'b1;
          rnd_d   = 4'd0;
`ifdef AES_ZEROIZE_EN
          state_d = '0;
          win_d   = '{default: '0};
`endif
        end else begin
          state_d = mc ^ rk;
          rnd_d   = rnd_q + 4'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= '0;
      win_q   <= '{default: '0};
      rnd_q   <= '0;
      ct_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      rnd_q   <= rnd_d;
      ct_q    <= ct_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin : fsm_reg
    if (reset) fsm_q <= ST_IDLE;
    else       fsm_q <= fsm_d;
  end

  always_comb begin : fsm_next
    fsm_d = fsm_q;
    case (fsm_q)
      ST_IDLE:  if (start_aes) fsm_d = ST_ROUND;
      ST_ROUND: if (last_rnd)  fsm_d = ST_IDLE;
      default:  fsm_d = ST_IDLE;
    endcase
  end

  always_comb begin : fsm_out
    busy           = (fsm_q == ST_ROUND);
    encryptor_done = done_q;
    ciphertext     = ct_q;
  end

endmodule
